// File: rtl/wave_dispatcher.sv
// Kernel-level wave scheduler: hands wave IDs to free SIMD units in round-robin
// order, tracks per-unit occupancy and pulses kernel_done once every wave has retired.
module wave_dispatcher #(
  parameter int NUM_SIMD      = 4,
  parameter int WAVE_ID_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [WAVE_ID_WIDTH-1:0] i_num_waves,
  input  logic [NUM_SIMD-1:0]      i_simd_wave_done,
  output logic [NUM_SIMD-1:0]      o_dispatch_new_wave,
  output logic [WAVE_ID_WIDTH-1:0] o_dispatch_wave_id,
  output logic [NUM_SIMD-1:0]      o_simd_enable,
  output logic                     o_busy,
  output logic                     o_kernel_done
);

  localparam int PTR_W = (NUM_SIMD > 1) ? $clog2(NUM_SIMD) : 1;
  localparam int CNT_W = WAVE_ID_WIDTH + 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]               r_state;
  logic [PTR_W-1:0]         r_rr_ptr;
  logic [CNT_W-1:0]         r_next_wave;
  logic [CNT_W-1:0]         r_completed;
  logic [WAVE_ID_WIDTH-1:0] r_num_waves;
  logic [NUM_SIMD-1:0]      r_occupied;

  logic [1:0]               w_state_next;
  logic [CNT_W-1:0]         w_count;
  logic [NUM_SIMD-1:0]      w_done_valid;
  logic [CNT_W-1:0]         w_done_count;
  logic [CNT_W-1:0]         w_completed_next;
  logic [CNT_W-1:0]         w_next_wave_inc;
  logic                     w_found;
  logic [NUM_SIMD-1:0]      w_sel_onehot;
  logic [PTR_W-1:0]         w_ptr_next;
  logic                     w_dispatch;

  assign o_simd_enable    = r_occupied;
  assign w_count          = {1'b0, r_num_waves};
  assign w_done_valid     = (r_state != S_IDLE) ? (i_simd_wave_done & r_occupied) : '0;
  assign w_completed_next = r_completed + w_done_count;
  assign w_next_wave_inc  = r_next_wave + CNT_W'(1);
  assign w_dispatch       = (r_state == S_DISPATCH) && (r_next_wave < w_count) && w_found;

  // Several units may retire in one cycle, so completions are counted, not flagged.
  always_comb begin
    w_done_count = '0;
    for (int i = 0; i < NUM_SIMD; i++) begin
      w_done_count = w_done_count + CNT_W'(w_done_valid[i]);
    end
  end

  // Round-robin scan from r_rr_ptr over the pre-edge occupancy; a unit freed
  // this cycle becomes eligible only on the following cycle.
  always_comb begin
    int                  idx;
    logic [NUM_SIMD-1:0] mask;
    w_found      = 1'b0;
    w_sel_onehot = '0;
    w_ptr_next   = r_rr_ptr;
    idx          = 0;
    mask         = '0;
    for (int k = 0; k < NUM_SIMD; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_SIMD) begin
        idx = idx - NUM_SIMD;
      end
      mask = NUM_SIMD'(1) << idx;
      if (!w_found && ((r_occupied & mask) == '0)) begin
        w_found      = 1'b1;
        w_sel_onehot = mask;
        w_ptr_next   = (idx == NUM_SIMD - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = (i_num_waves != '0) ? S_DISPATCH : S_DONE;
        end
      end
      S_DISPATCH: begin
        if (w_dispatch && (w_next_wave_inc == w_count)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_completed_next == w_count) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state             <= S_IDLE;
      r_rr_ptr            <= '0;
      r_next_wave         <= '0;
      r_completed         <= '0;
      r_num_waves         <= '0;
      r_occupied          <= '0;
      o_dispatch_new_wave <= '0;
      o_dispatch_wave_id  <= '0;
      o_busy              <= 1'b0;
      o_kernel_done       <= 1'b0;
    end else begin
      r_state             <= w_state_next;
      o_busy              <= (w_state_next != S_IDLE);
      o_kernel_done       <= (w_state_next == S_DONE);
      o_dispatch_new_wave <= w_dispatch ? w_sel_onehot : '0;
      o_dispatch_wave_id  <= w_dispatch ? r_next_wave[WAVE_ID_WIDTH-1:0] : '0;
      r_occupied          <= (r_occupied & ~w_done_valid) | (w_dispatch ? w_sel_onehot : '0);

      if (w_dispatch) begin
        r_next_wave <= w_next_wave_inc;
        r_rr_ptr    <= w_ptr_next;
      end

      // The round-robin pointer deliberately survives across launches.
      if ((r_state == S_IDLE) && i_start) begin
        r_num_waves <= i_num_waves;
        r_next_wave <= '0;
        r_completed <= '0;
      end else begin
        r_completed <= w_completed_next;
      end
    end
  end

endmodule
